// File: rtl/io_arbiter.sv
// io_arbiter
// Purpose: shares a single IO peripheral port between two requesters
// (m0 = CPU, m1 = debug loader). An access takes three cycles:
// IDLE (arbitrate and latch), XFER (bus strobes), RESP (done pulse).
// Arbitration is round-robin with a 1-bit priority pointer.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   mX_req                     requester X wants an access
//   mX_we, mX_addr, mX_wdata   access attributes, sampled only at grant
//   mX_gnt                     one-cycle pulse, X's access is on the bus
//   mX_done                    one-cycle pulse, X's access is complete
//   rdata                      last data read from the peripheral
//   pRead, pWrite              peripheral strobes (XFER only)
//   addr, pWriteData           peripheral address / write data (held)
//   pReadData                  peripheral read data, valid with pRead

module io_arbiter #(
   parameter int DW = 12,
   parameter int RW = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [1:0]    m0_addr,
   input  logic [DW-1:0] m0_wdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [1:0]    m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m0_gnt,
   output logic          m1_gnt,
   output logic          m0_done,
   output logic          m1_done,
   output logic [RW-1:0] rdata,
   output logic          pRead,
   output logic          pWrite,
   output logic [1:0]    addr,
   output logic [DW-1:0] pWriteData,
   input  logic [RW-1:0] pReadData
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic          ptr_q, ptr_d;
   logic          owner_q, owner_d;
   logic          we_q, we_d;
   logic [1:0]    addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [RW-1:0] rdata_q, rdata_d;
   logic          sel;

   // State and datapath registers; reset returns everything to a clean idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= 1'b0;
         owner_q <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Next-state logic. Requests are only looked at in IDLE, so changes on
   // req/we/addr/wdata during XFER or RESP cannot disturb the access.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      sel     = 1'b0;
      case (state_q)
         IDLE: begin
            if (m0_req || m1_req) begin
               // Both asking: the pointer decides. One asking: it wins.
               sel     = (m0_req && m1_req) ? ptr_q : m1_req;
               owner_d = sel;
               ptr_d   = ~sel;
               we_d    = sel ? m1_we    : m0_we;
               addr_d  = sel ? m1_addr  : m0_addr;
               wdata_d = sel ? m1_wdata : m0_wdata;
               state_d = XFER;
            end
         end
         XFER: begin
            if (!we_q) begin
               rdata_d = pReadData;
            end
            state_d = RESP;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs decode only from state and latched registers, never from req.
   assign m0_gnt     = (state_q == XFER) && !owner_q;
   assign m1_gnt     = (state_q == XFER) &&  owner_q;
   assign m0_done    = (state_q == RESP) && !owner_q;
   assign m1_done    = (state_q == RESP) &&  owner_q;
   assign pWrite     = (state_q == XFER) &&  we_q;
   assign pRead      = (state_q == XFER) && !we_q;
   assign addr       = addr_q;
   assign pWriteData = wdata_q;
   assign rdata      = rdata_q;

endmodule
